ifetch_sequencer: RTL

- Instruction-fetch front end of the multicycle CPU. It drives the IR load interface: the instruction word and write-enable that the IR register captures on the falling clock edge.
- Issues word reads to the instruction-side cache/IMEM over a req/ack handshake. Prefetches into a small buffer so decode rarely waits on SD/DDR-backed miss latency.
- Handles control-flow redirects, including discarding an in-flight read.

---
 rtl/ifetch_pkg.sv | 13 +
 rtl/ifetch_sequencer_if.sv | 25 ++
 rtl/ifetch_sequencer_fetch_buffer.sv | 67 ++++++
 rtl/ifetch_sequencer.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/ifetch_pkg.sv
// Shared constants and FSM encoding for the instruction-fetch front end.
package ifetch_pkg;

  localparam int unsigned INSTR_W      = 32;
  localparam int unsigned PC_INC       = 4;
  localparam logic [31:0] RESET_PC_DEF = 32'h0040_0000;

  localparam int unsigned STATE_W = 2;
  localparam logic [1:0]  S_IDLE  = 2'd0;
  localparam logic [1:0]  S_REQ   = 2'd1;
  localparam logic [1:0]  S_DRAIN = 2'd2;

endpackage

// File: rtl/ifetch_sequencer_if.sv
// Instruction-side cache read port: one outstanding req/ack word read.
interface ifetch_sequencer_if #(
  parameter int unsigned ADDR_W = 32
);

  logic                             imem_req;
  logic [ADDR_W-1:0]                imem_addr;
  logic                             imem_ack;
  logic [ifetch_pkg::INSTR_W-1:0]   imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );

endinterface

// File: rtl/ifetch_sequencer_fetch_buffer.sv
// Synchronous FIFO holding prefetched {pc, instr} entries; flush beats push.
module fetch_buffer #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 2,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             empty_o,
  output logic             full_o,
  output logic [CNT_W-1:0] count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok;
  logic             pop_ok;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // A push into a full buffer is accepted only when a pop frees the head slot.
  assign push_ok = push_i & ~flush_i & (~full_o | pop_i);
  assign pop_ok  = pop_i & ~flush_i & ~empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/ifetch_sequencer.sv
// Fetch FSM: prefetches words from the I-cache into a small buffer and feeds IR,
// discarding in-flight reads when control flow is redirected.
module ifetch_sequencer
  import ifetch_pkg::*;
#(
  parameter int unsigned       ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_PC  = ADDR_W'(RESET_PC_DEF),
  parameter int unsigned       BUF_DEPTH = 2
) (
  input  logic                clk,
  input  logic                rst,
  ifetch_sequencer_if.master  imem,
  input  logic                fetch_en,
  output logic                ir_write_ena,
  output logic [INSTR_W-1:0]  ir_data,
  output logic [ADDR_W-1:0]   ir_pc,
  input  logic                redirect,
  input  logic [ADDR_W-1:0]   redirect_pc,
  output logic                busy
);

  localparam int unsigned ENTRY_W = ADDR_W + INSTR_W;
  localparam int unsigned CNT_W   = $clog2(BUF_DEPTH + 1);
  localparam int unsigned OCC_W   = CNT_W + 1;

  logic [STATE_W-1:0] state_q, state_d;
  logic [ADDR_W-1:0]  fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic               req_q, req_d;

  logic [ADDR_W-1:0]  target_pc;
  logic [ADDR_W-1:0]  pc_inc;
  logic               push;
  logic               pop;
  logic [ENTRY_W-1:0] buf_head;
  logic               buf_empty;
  logic               buf_full;
  logic [CNT_W-1:0]   buf_count;
  logic [OCC_W-1:0]   occ_next;
  logic               has_space;
  logic               unused_bits;

  assign target_pc = {redirect_pc[ADDR_W-1:2], 2'b00};
  assign pc_inc    = fetch_pc_q + ADDR_W'(PC_INC);

  // IR delivery straight from the buffer head; a redirect squashes it.
  assign ir_write_ena = fetch_en & ~buf_empty & ~redirect & ~rst;
  assign busy         = fetch_en & buf_empty & ~rst;
  assign ir_pc        = buf_head[ENTRY_W-1:INSTR_W];
  assign ir_data      = buf_head[INSTR_W-1:0];
  assign pop          = ir_write_ena;

  assign push      = (state_q == S_REQ) & imem.imem_ack & ~redirect;
  assign occ_next  = redirect ? '0
                   : OCC_W'(buf_count) + OCC_W'(push) - OCC_W'(pop);
  assign has_space = (occ_next < OCC_W'(BUF_DEPTH));

  assign imem.imem_req  = req_q;
  assign imem.imem_addr = addr_q;

  assign unused_bits = ^{redirect_pc[1:0], buf_full};

  fetch_buffer #(
    .WIDTH (ENTRY_W),
    .DEPTH (BUF_DEPTH)
  ) u_buf (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .wdata_i ({fetch_pc_q, imem.imem_rdata}),
    .pop_i   (pop),
    .flush_i (redirect),
    .rdata_o (buf_head),
    .empty_o (buf_empty),
    .full_o  (buf_full),
    .count_o (buf_count)
  );

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    addr_d     = addr_q;
    req_d      = req_q;

    unique case (state_q)
      S_IDLE: begin
        if (redirect) fetch_pc_d = target_pc;
        if (has_space) begin
          state_d = S_REQ;
          req_d   = 1'b1;
          addr_d  = redirect ? target_pc : fetch_pc_q;
        end
      end

      S_REQ: begin
        if (redirect) begin
          fetch_pc_d = target_pc;
          if (imem.imem_ack) begin
            // Ack lands with the redirect: drop the word, refetch at once.
            addr_d = target_pc;
          end else begin
            state_d = S_DRAIN;
          end
        end else if (imem.imem_ack) begin
          fetch_pc_d = pc_inc;
          if (has_space) begin
            addr_d = pc_inc;
          end else begin
            state_d = S_IDLE;
            req_d   = 1'b0;
          end
        end
      end

      S_DRAIN: begin
        if (redirect) fetch_pc_d = target_pc;
        if (imem.imem_ack) begin
          state_d = S_REQ;
          req_d   = 1'b1;
          addr_d  = redirect ? target_pc : fetch_pc_q;
        end
      end

      default: begin
        state_d = S_IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      fetch_pc_q <= RESET_PC;
      addr_q     <= RESET_PC;
      req_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      addr_q     <= addr_d;
      req_q      <= req_d;
    end
  end

endmodule
